bcm_accumulator: RTL and testbench
==================================

# bcm_accumulator

Parametrised multi-pass bunch-current accumulator: sums `passCount` triggered passes of `rowCount` ADC beats per pass into an on-chip RAM, one accumulator per channel per sample lane. It replaces the fixed-width BCM acquisition core, adding per-pass triggering, pipeline-drain protection, overflow detection and a handshaked readout port. It sits entirely in the ADC clock domain; the CPU-side register bridge performs all clock crossing.

## Interface
- `CHANNEL_COUNT`, 4, ADC channels.
- `SAMPLES_PER_CLOCK`, 2, samples per channel per beat (power of two, ≥1).
- `SAMPLE_WIDTH`, 16, AXI field width; ADC value left-justified in it.
- `ADC_WIDTH`, 14, significant ADC bits.
- `ACC_WIDTH`, 20, accumulator width; `ACC_WIDTH+SAMPLE_WIDTH-ADC_WIDTH ≤ 32`.
- `SAMPLE_CAPACITY`, 1024, samples per channel; `ADDR_WIDTH = clog2(SAMPLE_CAPACITY/SAMPLES_PER_CLOCK)`.
- `MAX_PASSES`, 256, largest pass count; `PASS_WIDTH = clog2(MAX_PASSES)+1`.
- `adcClk  in  1  sole clock.`
- `adcRst_n  in  1  asynchronous, active-low reset.`
- `armStrobe  in  1  one-cycle; latch config, enter ARMED.`
- `abortStrobe  in  1  one-cycle; return to IDLE.`
- `passCount  in  PASS_WIDTH  passes per acquisition; 0 treated as 1.`
- `rowCount  in  ADDR_WIDTH  beats per pass; 0 means 2^ADDR_WIDTH.`
- `trigger  in  1  one-cycle pass trigger.`
- `inValid  in  1  beat valid.`
- `inData  in  CHANNEL_COUNT*SAMPLES_PER_CLOCK*SAMPLE_WIDTH  lane k at [k*SAMPLE_WIDTH+:SAMPLE_WIDTH], k = channel*SAMPLES_PER_CLOCK+sample.`
- `armed  out  1  waiting for trigger.`
- `busy  out  1  not IDLE.`
- `done  out  1  one-cycle pulse on completion.`
- `overflow  out  1  sticky; cleared by armStrobe.`
- `passesDone  out  PASS_WIDTH  completed passes.`
- `rdStrobe  in  1  readout request.`
- `rdAddr  in  ADDR_WIDTH  row.`
- `rdChannel  in  clog2(CHANNEL_COUNT) (min 1)  channel.`
- `rdSample  in  clog2(SAMPLES_PER_CLOCK) (min 1)  lane within row.`
- `rdValid  out  1  readout data valid pulse.`
- `rdData  out  32  signed accumulator, sign-extended, shifted left by SAMPLE_WIDTH-ADC_WIDTH.`

## Operation
- States: IDLE, ARMED, PASS, DRAIN.
- IDLE: `armStrobe` latches `passCount`/`rowCount`, clears `overflow` and `passesDone`, → ARMED.
- ARMED: `trigger` → PASS. `trigger` is ignored while in PASS or DRAIN.
- PASS: each `inValid` beat after the trigger cycle updates row `r` (0,1,2,…): RAM[r] += sign-extended ADC value, per lane. In pass 0, the old value is forced to 0, so no RAM clear is needed. Beats with `inValid=0` are skipped. After the `rowCount`-th beat → DRAIN.
- DRAIN: 3 cycles until the last write commits. Then `passesDone`+1. If passes remain → ARMED; otherwise pulse `done` and → IDLE.
- `abortStrobe` has priority over everything: → IDLE, in-flight writes dropped, no `done`, `passesDone` holds.
- `armStrobe` is ignored when not IDLE.
- `overflow` sets if any lane's true sum leaves the signed ACC_WIDTH range.
- Readout is serviced only in IDLE. `rdStrobe` while busy is ignored (no `rdValid`).

## Timing
- Reset values: state IDLE; `armed`, `busy`, `done`, `overflow`, `rdValid` = 0; `passesDone`, `rdData` = 0; RAM contents undefined.
- RMW pipeline:
  - cycle 0: beat accepted, RAM read issued;
  - cycle 1: RAM Q;
  - cycle 2: sum registered;
  - cycle 3: write.
- Rows within a pass are strictly increasing, so there is no read-after-write hazard. DRAIN guarantees no hazard across passes, even with `rowCount`=1.
- `done` asserts 4 cycles after the final beat. `busy` falls in the same cycle.
- `rdValid` and `rdData` follow `rdStrobe` by 2 cycles. Back-to-back strobes are fully pipelined.
- `armed` and `busy` are registered: valid the cycle after a state change.

## Configuration
- `BCM_ACC_SATURATE_EN` defined: on overflow the lane clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and `overflow` sets.
- Not defined: the lane wraps modulo 2^ACC_WIDTH, and `overflow` still sets. The saturation comparators are removed.

## Test plan
- CHANNEL_COUNT=2, SAMPLES_PER_CLOCK=2, passCount=4, rowCount=8, constant input 100, trigger each pass → `done` once; every lane of rows 0–7 reads 400<<2=1600; `passesDone`=4.
- Ramp input (beat n = n), `inValid` toggling every cycle, passCount=1, rowCount=16 → row r reads r; row 16 untouched.
- rowCount=1, passCount=3, trigger asserted every cycle → each pass waits for DRAIN; row 0 = 3×input, no lost or doubled sums.
- ACC_WIDTH=15, input +8191, passCount=8 → `overflow`=1; read +16383 with the macro defined, wrapped value without it.
- `abortStrobe` mid-pass 2 of 4 → `busy`=0 next cycle, no `done`, `passesDone`=1; a following `armStrobe` restarts cleanly.
- `adcRst_n` low mid-PASS → all outputs at reset values asynchronously; `rdStrobe` during busy yields no `rdValid`.

Source files
------------

// File: rtl/bcm_accumulator.sv
// bcm_accumulator: multi-pass bunch-current accumulator in the ADC clock domain.
// Sums passCount triggered passes of rowCount beats into an on-chip RAM, one
// accumulator per channel per sample lane, with a handshaked readout port.
// Optional feature macro BCM_ACC_SATURATE_EN: lanes clamp on overflow instead
// of wrapping modulo 2^ACC_WIDTH.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | configuration accepted, readout serviced
// S_ARMED | waiting for the pass trigger
// S_PASS  | accepting beats, one row per valid beat
// S_DRAIN | letting the last read-modify-write commit before next pass
module bcm_accumulator #(
    parameter int CHANNEL_COUNT     = 4,
    parameter int SAMPLES_PER_CLOCK = 2,
    parameter int SAMPLE_WIDTH      = 16,
    parameter int ADC_WIDTH         = 14,
    parameter int ACC_WIDTH         = 20,
    parameter int SAMPLE_CAPACITY   = 1024,
    parameter int MAX_PASSES        = 256,
    localparam int ADDR_WIDTH = $clog2(SAMPLE_CAPACITY / SAMPLES_PER_CLOCK),
    localparam int PASS_WIDTH = $clog2(MAX_PASSES) + 1,
    localparam int CH_WIDTH   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int SMP_WIDTH  = (SAMPLES_PER_CLOCK > 1) ? $clog2(SAMPLES_PER_CLOCK) : 1,
    localparam int LANES      = CHANNEL_COUNT * SAMPLES_PER_CLOCK
) (
    input  logic                            adcClk,
    input  logic                            adcRst_n,
    input  logic                            armStrobe,
    input  logic                            abortStrobe,
    input  logic [PASS_WIDTH-1:0]           passCount,
    input  logic [ADDR_WIDTH-1:0]           rowCount,
    input  logic                            trigger,
    input  logic                            inValid,
    input  logic [LANES*SAMPLE_WIDTH-1:0]   inData,
    output logic                            armed,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [PASS_WIDTH-1:0]           passesDone,
    input  logic                            rdStrobe,
    input  logic [ADDR_WIDTH-1:0]           rdAddr,
    input  logic [CH_WIDTH-1:0]             rdChannel,
    input  logic [SMP_WIDTH-1:0]            rdSample,
    output logic                            rdValid,
    output logic [31:0]                     rdData
);

    localparam int SHIFT  = SAMPLE_WIDTH - ADC_WIDTH;
    localparam int ROWS   = 2 ** ADDR_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W = LANES * ACC_WIDTH;
`ifdef BCM_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [PASS_WIDTH-1:0]   pass_cfg_q, pass_cfg_d, passes_done_q, passes_done_d;
    logic [PASS_WIDTH-1:0]   pass_eff, passes_next;
    logic [ADDR_WIDTH-1:0]   row_cfg_q, row_cfg_d, row_q, row_d;
    logic [1:0]              drain_q, drain_d;
    logic                    armed_q, armed_d, busy_q, busy_d, done_q, done_d;
    logic                    overflow_q, overflow_d, beat;

    logic                    s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
    logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [LANES*ADC_WIDTH-1:0] s1_adc_q, s1_adc_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [WORD_W-1:0]       s2_sum_q, s2_sum_d;
    logic [ACC_WIDTH:0]      old_v, adc_v, sum_v;
    logic                    lane_ovf, ovf_any;

    logic                    rd1_vld_q, rd1_vld_d, rd1_ok_q, rd1_ok_d;
    logic [LANE_W-1:0]       rd1_lane_q, rd1_lane_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic [ACC_WIDTH-1:0]    rd_acc;
    int                      lane_idx;

    logic [WORD_W-1:0]       mem [ROWS];
    logic [WORD_W-1:0]       mem_rd_q;
    logic [ADDR_WIDTH-1:0]   mem_raddr;
    logic                    mem_we;
    logic                    unused_lsbs;

    // The low bits of each AXI field below the ADC value carry no information.
    assign unused_lsbs = ^inData;

    assign mem_raddr = (state_q == S_IDLE) ? rdAddr : row_q;
    assign mem_we    = s2_vld_q && !abortStrobe;
    assign pass_eff    = (pass_cfg_q == '0) ? PASS_WIDTH'(1) : pass_cfg_q;
    assign passes_next = passes_done_q + PASS_WIDTH'(1);

    // Sequencer next-state: abort overrides every other request.
    always_comb begin
        state_d       = state_q;
        pass_cfg_d    = pass_cfg_q;
        row_cfg_d     = row_cfg_q;
        passes_done_d = passes_done_q;
        row_d         = row_q;
        drain_d       = drain_q;
        done_d        = 1'b0;
        beat          = 1'b0;
        overflow_d    = overflow_q | (s1_vld_q & ovf_any);
        if (abortStrobe) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armStrobe) begin
                        pass_cfg_d    = passCount;
                        row_cfg_d     = rowCount;
                        passes_done_d = '0;
                        overflow_d    = 1'b0;
                        state_d       = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        row_d   = '0;
                        state_d = S_PASS;
                    end
                end
                S_PASS: begin
                    if (inValid) begin
                        beat  = 1'b1;
                        row_d = row_q + ADDR_WIDTH'(1);
                        // rowCount of 0 wraps to all-ones here, giving 2^ADDR_WIDTH beats.
                        if (row_q == row_cfg_q - ADDR_WIDTH'(1)) begin
                            drain_d = 2'd2;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q != 2'd0) begin
                        drain_d = drain_q - 2'd1;
                    end else begin
                        passes_done_d = passes_next;
                        if (passes_next >= pass_eff) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        armed_d = (state_d == S_ARMED);
        busy_d  = (state_d != S_IDLE);
    end

    // Read-modify-write pipeline: stage 1 holds the beat, stage 2 the lane sums.
    always_comb begin
        s1_vld_d   = beat;
        s1_addr_d  = row_q;
        s1_first_d = (passes_done_q == '0);
        s1_adc_d   = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_adc_d[k*ADC_WIDTH +: ADC_WIDTH] = inData[k*SAMPLE_WIDTH + SHIFT +: ADC_WIDTH];
        end
        s2_vld_d  = s1_vld_q && !abortStrobe;
        s2_addr_d = s1_addr_q;
        s2_sum_d  = '0;
        ovf_any   = 1'b0;
        old_v     = '0;
        adc_v     = '0;
        sum_v     = '0;
        lane_ovf  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            // Pass 0 ignores stale RAM contents, so no clear sweep is needed.
            old_v = s1_first_q ? '0 :
                    {mem_rd_q[k*ACC_WIDTH+ACC_WIDTH-1], mem_rd_q[k*ACC_WIDTH +: ACC_WIDTH]};
            adc_v = {{(ACC_WIDTH+1-ADC_WIDTH){s1_adc_q[k*ADC_WIDTH+ADC_WIDTH-1]}},
                     s1_adc_q[k*ADC_WIDTH +: ADC_WIDTH]};
            sum_v    = old_v + adc_v;
            lane_ovf = sum_v[ACC_WIDTH] ^ sum_v[ACC_WIDTH-1];
            ovf_any  = ovf_any | lane_ovf;
`ifdef BCM_ACC_SATURATE_EN
            if (lane_ovf) begin
                s2_sum_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                s2_sum_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_v[ACC_WIDTH-1:0];
            end
`else
            s2_sum_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_v[ACC_WIDTH-1:0];
`endif
        end
    end

    // Readout path: lane select after the RAM read, sign-extend and re-justify.
    always_comb begin
        lane_idx   = int'(rdChannel) * SAMPLES_PER_CLOCK + int'(rdSample);
        rd1_vld_d  = rdStrobe && (state_q == S_IDLE);
        rd1_lane_d = LANE_W'(lane_idx);
        rd1_ok_d   = (lane_idx < LANES) && (int'(rdSample) < SAMPLES_PER_CLOCK);
        rd_acc     = '0;
        for (int k = 0; k < LANES; k++) begin
            if (rd1_ok_q && (rd1_lane_q == LANE_W'(k))) begin
                rd_acc = mem_rd_q[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
        rd_valid_d = rd1_vld_q;
        rd_data_d  = rd1_vld_q ? ({{(32-ACC_WIDTH){rd_acc[ACC_WIDTH-1]}}, rd_acc} << SHIFT)
                               : rd_data_q;
    end

    // Control, pipeline and readout registers.
    always_ff @(posedge adcClk or negedge adcRst_n) begin
        if (!adcRst_n) begin
            state_q       <= S_IDLE;
            pass_cfg_q    <= '0;
            row_cfg_q     <= '0;
            passes_done_q <= '0;
            row_q         <= '0;
            drain_q       <= '0;
            armed_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_adc_q      <= '0;
            s2_vld_q      <= 1'b0;
            s2_addr_q     <= '0;
            s2_sum_q      <= '0;
            rd1_vld_q     <= 1'b0;
            rd1_ok_q      <= 1'b0;
            rd1_lane_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            pass_cfg_q    <= pass_cfg_d;
            row_cfg_q     <= row_cfg_d;
            passes_done_q <= passes_done_d;
            row_q         <= row_d;
            drain_q       <= drain_d;
            armed_q       <= armed_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            s1_vld_q      <= s1_vld_d;
            s1_first_q    <= s1_first_d;
            s1_addr_q     <= s1_addr_d;
            s1_adc_q      <= s1_adc_d;
            s2_vld_q      <= s2_vld_d;
            s2_addr_q     <= s2_addr_d;
            s2_sum_q      <= s2_sum_d;
            rd1_vld_q     <= rd1_vld_d;
            rd1_ok_q      <= rd1_ok_d;
            rd1_lane_q    <= rd1_lane_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Accumulator RAM: one registered read port shared by pipeline and readout.
    always_ff @(posedge adcClk) begin
        if (mem_we) begin
            mem[s2_addr_q] <= s2_sum_q;
        end
        mem_rd_q <= mem[mem_raddr];
    end

    assign armed      = armed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign passesDone = passes_done_q;
    assign rdValid    = rd_valid_q;
    assign rdData     = rd_data_q;

endmodule

// File: tb/tb_bcm_accumulator.sv
// Directed bench for bcm_accumulator (2 channels x 2 samples, 15-bit accumulators).
module tb_bcm_accumulator;

    localparam int CH    = 2;
    localparam int SPC   = 2;
    localparam int LANES = CH * SPC;
    localparam int AW    = 9;
    localparam int PW    = 9;

    logic              adcClk, adcRst_n;
    logic              armStrobe, abortStrobe, trigger, inValid;
    logic [PW-1:0]     passCount;
    logic [AW-1:0]     rowCount;
    logic [LANES*16-1:0] inData;
    logic              armed, busy, done, overflow;
    logic [PW-1:0]     passesDone;
    logic              rdStrobe, rdValid;
    logic [AW-1:0]     rdAddr;
    logic [0:0]        rdChannel, rdSample;
    logic [31:0]       rdData;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_beat_cyc = 0, done_base = 0;
    logic busy_at_done = 1'b1;

    bcm_accumulator #(
        .CHANNEL_COUNT(CH), .SAMPLES_PER_CLOCK(SPC), .SAMPLE_WIDTH(16),
        .ADC_WIDTH(14), .ACC_WIDTH(15), .SAMPLE_CAPACITY(1024), .MAX_PASSES(256)
    ) dut (
        .adcClk(adcClk), .adcRst_n(adcRst_n), .armStrobe(armStrobe),
        .abortStrobe(abortStrobe), .passCount(passCount), .rowCount(rowCount),
        .trigger(trigger), .inValid(inValid), .inData(inData), .armed(armed),
        .busy(busy), .done(done), .overflow(overflow), .passesDone(passesDone),
        .rdStrobe(rdStrobe), .rdAddr(rdAddr), .rdChannel(rdChannel),
        .rdSample(rdSample), .rdValid(rdValid), .rdData(rdData)
    );

    initial begin
        adcClk = 1'b0;
        forever #5 adcClk = ~adcClk;
    end

    always @(posedge adcClk) cyc <= cyc + 1;

    always @(negedge adcClk) begin
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge adcClk);
    endtask

    task automatic set_data(input int base, input int step);
        for (int k = 0; k < LANES; k++) inData[k*16 +: 16] = 16'((base + step * k) * 4);
    endtask

    task automatic arm(input int pc, input int rc);
        armStrobe = 1'b1; passCount = PW'(pc); rowCount = AW'(rc);
        tick();
        armStrobe = 1'b0;
    endtask

    task automatic trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic run_beats(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            inValid = 1'b1;
            set_data(base, step);
            last_beat_cyc = cyc;
            tick();
        end
        inValid = 1'b0;
    endtask

    task automatic wait_armed(input string tag);
        for (int i = 0; i < 50 && !armed; i++) tick();
        check(tag, armed, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check(tag, busy, 1'b0);
    endtask

    task automatic read_chk(input string tag, input int row, input int ch, input int smp,
                            input logic [31:0] exp);
        rdStrobe = 1'b1; rdAddr = AW'(row); rdChannel = 1'(ch); rdSample = 1'(smp);
        tick();
        rdStrobe = 1'b0;
        tick();
        check(tag, rdValid ? rdData : 32'hBAD0BAD0, exp);
    endtask

    initial begin
        adcRst_n = 1'b0; armStrobe = 1'b0; abortStrobe = 1'b0; trigger = 1'b0;
        inValid = 1'b0; passCount = '0; rowCount = '0; inData = '0;
        rdStrobe = 1'b0; rdAddr = '0; rdChannel = '0; rdSample = '0;
        #2;
        check("rst_armed", armed, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_passes", passesDone, 0);
        check("rst_rdvalid", rdValid, 0);
        check("rst_rddata", rdData, 0);
        repeat (3) tick();
        adcRst_n = 1'b1;
        tick();

        // Four passes of constant 100 over eight rows.
        done_base = done_cnt;
        arm(4, 8);
        for (int p = 0; p < 4; p++) begin
            wait_armed($sformatf("t1_armed_p%0d", p));
            trig();
            run_beats(8, 100, 0);
        end
        wait_idle("t1_idle", 50);
        tick();
        check("t1_done_cnt", done_cnt - done_base, 1);
        check("t1_done_lat", done_cyc - last_beat_cyc, 4);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_passes", passesDone, 4);
        check("t1_ovf", overflow, 0);
        for (int r = 0; r < 8; r += 7)
            for (int l = 0; l < LANES; l++)
                read_chk($sformatf("t1_row%0d_lane%0d", r, l), r, l / SPC, l % SPC, 32'd1600);
        // Back-to-back readout strobes.
        rdStrobe = 1'b1; rdAddr = AW'(2); rdChannel = 1'b1; rdSample = 1'b1;
        tick();
        rdAddr = AW'(5); rdChannel = 1'b0; rdSample = 1'b0;
        tick();
        rdStrobe = 1'b0;
        check("t1_b2b_a", rdValid ? rdData : 32'hBAD0BAD0, 32'd1600);
        tick();
        check("t1_b2b_b", rdValid ? rdData : 32'hBAD0BAD0, 32'd1600);

        // Background fill of rows 0..19 with 55.
        arm(1, 20);
        trig();
        run_beats(20, 55, 0);
        wait_idle("t2_fill_idle", 50);

        // Ramp with inValid toggling, sixteen rows, single pass.
        arm(1, 16);
        trig();
        for (int n = 0; n < 16; n++) begin
            inValid = 1'b1; set_data(n, 0);
            tick();
            inValid = 1'b0; set_data(777, 0);
            tick();
        end
        wait_idle("t2_idle", 50);
        read_chk("t2_row0", 0, 0, 0, 32'd0);
        read_chk("t2_row5", 5, 1, 1, 32'd20);
        read_chk("t2_row9", 9, 1, 0, 32'd36);
        read_chk("t2_row15", 15, 0, 1, 32'd60);
        read_chk("t2_row16_untouched", 16, 0, 0, 32'd220);

        // rowCount=1, three passes, trigger and inValid held high throughout.
        done_base = done_cnt;
        arm(3, 1);
        trigger = 1'b1; inValid = 1'b1; set_data(7, 0);
        wait_idle("t3_idle", 100);
        trigger = 1'b0; inValid = 1'b0;
        tick();
        check("t3_done_cnt", done_cnt - done_base, 1);
        check("t3_passes", passesDone, 3);
        check("t3_ovf", overflow, 0);
        read_chk("t3_row0", 0, 1, 1, 32'd84);
        read_chk("t3_row1", 1, 0, 0, 32'd4);

        // Overflow: +8191 over eight passes into 15-bit accumulators.
        arm(8, 1);
        trigger = 1'b1; inValid = 1'b1; set_data(8191, 0);
        wait_idle("t4_idle", 200);
        trigger = 1'b0; inValid = 1'b0;
        tick();
        check("t4_ovf", overflow, 1);
        check("t4_passes", passesDone, 8);
`ifdef BCM_ACC_SATURATE_EN
        read_chk("t4_row0_sat", 0, 0, 1, 32'h0000FFFC);
`else
        read_chk("t4_row0_wrap", 0, 0, 1, 32'hFFFFFFE0);
`endif

        // Abort during the second of four passes, then a clean restart.
        done_base = done_cnt;
        arm(4, 4);
        check("t5_ovf_cleared", overflow, 0);
        trig();
        run_beats(4, 50, 0);
        wait_armed("t5_armed");
        trig();
        run_beats(2, 50, 0);
        abortStrobe = 1'b1;
        tick();
        abortStrobe = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        check("t5_armed_after_abort", armed, 0);
        repeat (8) tick();
        check("t5_no_done", done_cnt - done_base, 0);
        check("t5_passes_hold", passesDone, 1);
        arm(1, 4);
        trig();
        run_beats(4, 9, 3);
        wait_idle("t5_restart_idle", 50);
        tick();
        check("t5_restart_done", done_cnt - done_base, 1);
        check("t5_restart_passes", passesDone, 1);
        for (int l = 0; l < LANES; l++)
            read_chk($sformatf("t5_row3_lane%0d", l), 3, l / SPC, l % SPC, 32'((9 + 3 * l) * 4));

        // Readout ignored while busy, then asynchronous reset mid-pass.
        arm(2, 6);
        trig();
        run_beats(6, 5, 0);
        wait_armed("t6_armed");
        trig();
        run_beats(2, 5, 0);
        rdStrobe = 1'b1; rdAddr = '0;
        tick();
        rdStrobe = 1'b0;
        tick();
        check("t6_rd_busy_vld", rdValid, 0);
        tick();
        check("t6_rd_busy_vld2", rdValid, 0);
        check("t6_rddata_hold", rdData, 32'd72);
        check("t6_passes_pre", passesDone, 1);
        check("t6_busy_pre", busy, 1);
        #2 adcRst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_armed", armed, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_passes", passesDone, 0);
        check("t6_rst_rdvalid", rdValid, 0);
        check("t6_rst_rddata", rdData, 0);
        tick();
        tick();
        adcRst_n = 1'b1;
        tick();
        arm(1, 2);
        trig();
        run_beats(2, 4, 1);
        wait_idle("t6_recover_idle", 50);
        read_chk("t6_recover_row1", 1, 1, 0, 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
